// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: valid/ready request, valid response, response timeout.
// Optional byte-lane loads/stores are enabled by defining MA_BYTE_ACCESS_EN.
module mem_access_stage #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned REG_IDX_W = 5,
    parameter int unsigned CTRL_W    = 4,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_ex,
    input  logic [CTRL_W-1:0]      control_ex,
    input  logic [DATA_W-1:0]      result_ex,
    input  logic [DATA_W-1:0]      reg_data_ex,
    input  logic [REG_IDX_W-1:0]   dest_reg_index_ex,
    input  logic                   dest_reg_write_en_ex,
    output logic                   stall_ma,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_write,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic [DATA_W/8-1:0]    mem_wstrb,
    input  logic                   mem_rsp_valid,
    input  logic [DATA_W-1:0]      mem_rsp_data,
    output logic                   valid_ma,
    output logic [REG_IDX_W-1:0]   dest_reg_index_ma,
    output logic                   dest_reg_write_en_ma,
    output logic [DATA_W-1:0]      result_ma,
    output logic [DATA_W-1:0]      data_ma,
    output logic [CTRL_W-1:0]      control_ma,
    output logic                   err_ma
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT);
    localparam logic [1:0]  OP_LOAD  = 2'b01;
    localparam logic [1:0]  OP_STORE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]     cnt;
    logic                 hold_write;
    logic [ADDR_W-1:0]    hold_addr;
    logic [DATA_W-1:0]    hold_wdata;
    logic [STRB_W-1:0]    hold_wstrb;
    logic [DATA_W-1:0]    hold_result;
    logic [CTRL_W-1:0]    hold_ctrl;
    logic [REG_IDX_W-1:0] hold_idx;
    logic                 hold_we;

    logic                 is_mem_op;
    logic                 complete_none;
    logic                 capture;
    logic                 req_fire;
    logic                 rsp_take;
    logic                 timeout_hit;
    logic [ADDR_W-1:0]    req_addr;
    logic [DATA_W-1:0]    req_wdata;
    logic [STRB_W-1:0]    req_wstrb;
    logic [DATA_W-1:0]    rsp_data_proc;

    assign is_mem_op = (control_ex[1:0] == OP_LOAD) || (control_ex[1:0] == OP_STORE);

`ifdef MA_BYTE_ACCESS_EN
    localparam int unsigned LB   = $clog2(STRB_W);
    localparam int unsigned LB_W = (LB == 0) ? 1 : LB;

    logic [LB_W-1:0] lane;
    logic [LB_W-1:0] hold_lane;
    logic [7:0]      rsp_byte;

    // Low address bits pick the byte lane; the rest form the word address.
    assign lane     = (LB == 0) ? '0 : LB_W'(result_ex);
    assign req_addr = ADDR_W'(result_ex >> LB);

    always_comb begin
        req_wdata = reg_data_ex;
        req_wstrb = '1;
        if (control_ex[2]) begin
            req_wdata = {STRB_W{reg_data_ex[7:0]}};
            req_wstrb = STRB_W'(1) << lane;
        end
    end

    assign rsp_byte = mem_rsp_data[{hold_lane, 3'b000} +: 8];

    always_comb begin
        rsp_data_proc = mem_rsp_data;
        if (hold_ctrl[2]) begin
            rsp_data_proc = hold_ctrl[3] ? DATA_W'(rsp_byte) : DATA_W'($signed(rsp_byte));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_lane <= '0;
        end else if (capture) begin
            hold_lane <= lane;
        end
    end
`else
    assign req_addr      = result_ex[ADDR_W-1:0];
    assign req_wdata     = reg_data_ex;
    assign req_wstrb     = '1;
    assign rsp_data_proc = mem_rsp_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        complete_none = 1'b0;
        capture       = 1'b0;
        req_fire      = 1'b0;
        rsp_take      = 1'b0;
        timeout_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (valid_ex) begin
                    if (is_mem_op) begin
                        capture    = 1'b1;
                        state_next = S_REQ;
                    end else begin
                        complete_none = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    req_fire   = 1'b1;
                    state_next = hold_write ? S_IDLE : S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                // A response arriving on the timeout cycle still completes normally.
                if (mem_rsp_valid) begin
                    rsp_take   = 1'b1;
                    state_next = S_IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Response timeout counter, restarted on every accepted load request.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (req_fire) begin
            cnt <= '0;
        end else if (state == S_WAIT_RSP && !rsp_take && !timeout_hit) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Holding registers keep the request stable while the stage is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_write  <= 1'b0;
            hold_addr   <= '0;
            hold_wdata  <= '0;
            hold_wstrb  <= '1;
            hold_result <= '0;
            hold_ctrl   <= '0;
            hold_idx    <= '0;
            hold_we     <= 1'b0;
        end else if (capture) begin
            hold_write  <= (control_ex[1:0] == OP_STORE);
            hold_addr   <= req_addr;
            hold_wdata  <= req_wdata;
            hold_wstrb  <= req_wstrb;
            hold_result <= result_ex;
            hold_ctrl   <= control_ex;
            hold_idx    <= dest_reg_index_ex;
            hold_we     <= dest_reg_write_en_ex;
        end
    end

    assign stall_ma      = (state != S_IDLE);
    assign mem_req_valid = (state == S_REQ);
    assign mem_req_write = hold_write;
    assign mem_addr      = hold_addr;
    assign mem_wdata     = hold_wdata;
    assign mem_wstrb     = hold_wstrb;

    // Stage outputs: valid/err/write-enable pulse for one cycle per instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_ma             <= 1'b0;
            dest_reg_index_ma    <= '0;
            dest_reg_write_en_ma <= 1'b0;
            result_ma            <= '0;
            data_ma              <= '0;
            control_ma           <= '0;
            err_ma               <= 1'b0;
        end else begin
            valid_ma             <= 1'b0;
            dest_reg_write_en_ma <= 1'b0;
            err_ma               <= 1'b0;
            if (complete_none) begin
                valid_ma             <= 1'b1;
                dest_reg_index_ma    <= dest_reg_index_ex;
                dest_reg_write_en_ma <= dest_reg_write_en_ex;
                result_ma            <= result_ex;
                data_ma              <= '0;
                control_ma           <= control_ex;
            end else if (req_fire && hold_write) begin
                valid_ma             <= 1'b1;
                dest_reg_index_ma    <= hold_idx;
                dest_reg_write_en_ma <= hold_we;
                result_ma            <= hold_result;
                data_ma              <= '0;
                control_ma           <= hold_ctrl;
            end else if (rsp_take) begin
                valid_ma             <= 1'b1;
                dest_reg_index_ma    <= hold_idx;
                dest_reg_write_en_ma <= hold_we;
                result_ma            <= hold_result;
                data_ma              <= rsp_data_proc;
                control_ma           <= hold_ctrl;
            end else if (timeout_hit) begin
                valid_ma             <= 1'b1;
                err_ma               <= 1'b1;
                dest_reg_index_ma    <= hold_idx;
                result_ma            <= hold_result;
                data_ma              <= '0;
                control_ma           <= hold_ctrl;
            end
        end
    end

endmodule
